// File: rtl/aes_display_pkg.sv
// Shared types and sizing for the AES block display sequencer.
package aes_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHOW
  } state_t;

  localparam int BCD_W     = 12;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 16;
  localparam int DD_ITERS  = 8;

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: one add-3/shift iteration per cycle, 8-bit binary to 3-digit BCD.
module bin2bcd_serial
  import aes_display_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] bin_in,
  output logic              done,
  output logic [BCD_W-1:0]  bcd_out
);

  localparam int SR_W   = BCD_W + BYTE_W;
  localparam int ITER_W = $clog2(DD_ITERS + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DD_ITERS);

  logic [SR_W-1:0]   shift_p0;
  logic [ITER_W-1:0] iter_p0;

  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] r);
    logic [SR_W-1:0] a;
    a = r;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (a[BYTE_W+4*k +: 4] >= 4'd5)
        a[BYTE_W+4*k +: 4] = a[BYTE_W+4*k +: 4] + 4'd3;
    end
    return a << 1;
  endfunction

  // start performs the first iteration directly on the fresh byte; a new start aborts any run
  always_ff @(posedge clk) begin
    if (reset)
      iter_p0 <= '0;
    else if (start)
      iter_p0 <= ITER_W'(1);
    else if (iter_p0 == ITER_LAST)
      iter_p0 <= '0;
    else if (iter_p0 != '0)
      iter_p0 <= iter_p0 + ITER_W'(1);
  end

  always_ff @(posedge clk) begin
    if (start)
      shift_p0 <= dd_step({{BCD_W{1'b0}}, bin_in});
    else if (iter_p0 != '0 && iter_p0 != ITER_LAST)
      shift_p0 <= dd_step(shift_p0);
  end

  assign done    = (iter_p0 == ITER_LAST);
  assign bcd_out = shift_p0[SR_W-1 -: BCD_W];

endmodule

// File: rtl/aes_display_scheduler.sv
// Steps through the 16 bytes of a captured AES block, converting each to BCD for the
// seven-segment decoder and holding it for DWELL_CYCLES.
module aes_display_scheduler #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int NUM_BYTES    = aes_display_pkg::NUM_BYTES
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_BYTES*aes_display_pkg::BYTE_W-1:0] data_in,
  input  logic                                     load,
  input  logic                                     hold,
  output logic [aes_display_pkg::BCD_W-1:0]        word_out,
  output logic [$clog2(NUM_BYTES)-1:0]             byte_idx,
  output logic                                     valid,
  output logic                                     busy
);

  import aes_display_pkg::*;

  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t state, state_nxt;

  logic [NUM_BYTES-1:0][BYTE_W-1:0] block;
  logic [IDX_W-1:0]  conv_idx, idx_next;
  logic [CNT_W-1:0]  dwell_cnt;
  logic [BYTE_W-1:0] cur_byte;
  logic [BCD_W-1:0]  dd_bcd;
  logic              dd_done;
  logic              start_p0, start_nxt;
  logic              advance, latch;

  // byte 0 sits in the most significant lane of the block
  assign cur_byte = block[IDX_W'(NUM_BYTES - 1) - conv_idx];
  assign idx_next = (conv_idx == IDX_W'(NUM_BYTES - 1)) ? '0 : conv_idx + IDX_W'(1);

  bin2bcd_serial u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (start_p0),
    .bin_in  (cur_byte),
    .done    (dd_done),
    .bcd_out (dd_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // done is ignored while a fresh start is pending so an aborted run never reaches the display
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    advance   = 1'b0;
    latch     = 1'b0;
    unique case (state)
      IDLE: begin
      end
      CONVERT: begin
        if (dd_done && !start_p0) begin
          latch     = 1'b1;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (!hold && dwell_cnt == DWELL_LAST) begin
          advance   = 1'b1;
          start_nxt = 1'b1;
          state_nxt = CONVERT;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      advance   = 1'b0;
      latch     = 1'b0;
      start_nxt = 1'b1;
      state_nxt = CONVERT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      block     <= '0;
      conv_idx  <= '0;
      start_p0  <= 1'b0;
      dwell_cnt <= '0;
      word_out  <= '0;
      byte_idx  <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      start_p0 <= start_nxt;
      busy     <= (state_nxt == CONVERT);
      if (load) begin
        block    <= data_in;
        conv_idx <= '0;
      end else if (advance) begin
        conv_idx <= idx_next;
      end
      if (latch) begin
        word_out <= dd_bcd;
        byte_idx <= conv_idx;
        valid    <= 1'b1;
      end
      if (state == SHOW && state_nxt == SHOW) begin
        if (!hold) dwell_cnt <= dwell_cnt + CNT_W'(1);
      end else begin
        dwell_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_display_scheduler.sv
// Scoreboard bench for aes_display_scheduler with DWELL_CYCLES=4 (13-cycle byte period).
module tb_aes_display_scheduler;

  localparam int DWELL = 4;
  localparam int PER   = DWELL + 9;

  logic         clk = 1'b0;
  logic         reset, load, hold;
  logic [127:0] data_in;
  logic [11:0]  word_out;
  logic [3:0]   byte_idx;
  logic         valid, busy;

  aes_display_scheduler #(.DWELL_CYCLES(DWELL), .NUM_BYTES(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load     (load),
    .hold     (hold),
    .word_out (word_out),
    .byte_idx (byte_idx),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] word;
    logic [3:0]  idx;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_busy = 1'b0;

  localparam logic [127:0] BLK_A = 128'h00FF8063_090A64C8_00000000_00000000;
  localparam logic [127:0] BLK_B = 128'hEA05FA00_00000000_00000000_00000000;
  localparam logic [127:0] BLK_C = 128'h7B2A0000_00000000_00000000_00000000;
  localparam logic [127:0] BLK_D = 128'h64FF0000_00000000_00000000_00000000;

  logic [11:0] exp_a [16] = '{12'h000, 12'h255, 12'h128, 12'h099,
                              12'h009, 12'h010, 12'h100, 12'h200,
                              12'h000, 12'h000, 12'h000, 12'h000,
                              12'h000, 12'h000, 12'h000, 12'h000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [11:0] w, input logic [3:0] i, input int at);
    exp_t e;
    e.word = w;
    e.idx  = i;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    if (cyc > n) begin
      checks++;
      errors++;
      $display("FAIL schedule actual=%0d required=%0d", cyc, n);
    end
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every completed conversion (busy falling with valid set) is one DUT output
  always @(negedge clk) begin
    if (prev_busy && !busy && valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h idx=%0d required=none (cycle %0d)",
                 word_out, byte_idx, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_word", 32'(word_out), 32'(e.word));
        chk("sb_idx",  32'(byte_idx), 32'(e.idx));
        chk("sb_time", cyc,           e.at);
      end
    end
    prev_busy <= busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=%0d required=finish", cyc);
    $fatal(1);
  end

  int e0, t0, a3, c0, r0, e2;

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    hold    = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_word",  32'(word_out), 32'h0);
    chk("rst_idx",   32'(byte_idx), 32'h0);
    chk("rst_valid", 32'(valid),    32'h0);
    chk("rst_busy",  32'(busy),     32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);

    // block A: full lap plus wrap, then the start of a second lap
    data_in = BLK_A;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    e0 = cyc;
    t0 = e0 + 9;
    for (int i = 0; i < 20; i++) push_exp(exp_a[i % 16], 4'(i % 16), t0 + PER * i);
    chk("busy_rise", 32'(busy), 32'h1);
    wait_cyc(e0 + 8);
    chk("pre_valid", 32'(valid),    32'h0);
    chk("pre_word",  32'(word_out), 32'h0);
    chk("pre_busy",  32'(busy),     32'h1);
    wait_cyc(t0);
    chk("first_valid", 32'(valid), 32'h1);
    chk("first_busy",  32'(busy),  32'h0);

    // hold for 20 cycles at the start of byte 3's SHOW (second lap)
    a3 = t0 + PER * 19;
    wait_cyc(a3);
    hold = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("hold_word", 32'(word_out), 32'h099);
      chk("hold_idx",  32'(byte_idx), 32'h3);
    end
    hold = 1'b0;
    push_exp(12'h009, 4'd4, a3 + 33);

    // reload on the 4th CONVERT cycle of byte 5
    c0 = a3 + 33 + DWELL;
    wait_cyc(c0 + 3);
    data_in = BLK_B;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    r0 = cyc;
    push_exp(12'h234, 4'd0, r0 + 9);
    push_exp(12'h005, 4'd1, r0 + 9 + PER);
    push_exp(12'h250, 4'd2, r0 + 9 + 2 * PER);
    for (int j = 0; j < 9; j++) begin
      chk("reload_hold_word", 32'(word_out), 32'h009);
      chk("reload_hold_idx",  32'(byte_idx), 32'h4);
      if (j < 8) @(negedge clk);
    end

    // load on the same edge as byte 2's terminal count
    wait_cyc(r0 + 38);
    data_in = BLK_C;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_exp(12'h123, 4'd0, r0 + 48);
    push_exp(12'h042, 4'd1, r0 + 48 + PER);

    // reset during SHOW of byte 1
    wait_cyc(r0 + 62);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_word",  32'(word_out), 32'h0);
    chk("mid_rst_idx",   32'(byte_idx), 32'h0);
    chk("mid_rst_valid", 32'(valid),    32'h0);
    chk("mid_rst_busy",  32'(busy),     32'h0);
    hold = 1'b1;
    repeat (10) @(negedge clk);
    hold = 1'b0;
    repeat (30) @(negedge clk);
    chk("idle_after_rst_busy",  32'(busy),     32'h0);
    chk("idle_after_rst_valid", 32'(valid),    32'h0);
    chk("idle_after_rst_word",  32'(word_out), 32'h0);
    chk("sb_drained_mid", sb.size(), 0);

    // load with hold already high: conversion completes, dwell waits for hold to fall
    data_in = BLK_D;
    load    = 1'b1;
    hold    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    e2 = cyc;
    push_exp(12'h100, 4'd0, e2 + 9);
    push_exp(12'h255, 4'd1, e2 + 15 + PER);
    wait_cyc(e2 + 15);
    chk("hold_conv_idx", 32'(byte_idx), 32'h0);
    hold = 1'b0;
    wait_cyc(e2 + 15 + PER + 3);

    chk("sb_drained_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
